brief_desc_collector: RTL
=========================

// Module: brief_desc_collector
// PURPOSE
//  Receiving end of the BRIEF descriptor stream. Captures per-frame keypoint records
//  (x, y, score, depth, 256b descriptor) framed by start/end pulses into a ping-pong
//  bank pair, then drains each completed frame to the matcher over a valid/ready port.
//  Sits between the BRIEF stage and the frame-to-frame matcher.
// PARAMETERS
//  DEPTH   128   records per bank (max keypoints per frame); ADDR_W = $clog2(DEPTH)
// PORTS
//  i_clk            in   1    clock
//  i_rst            in   1    synchronous active-high reset
//  i_start          in   1    frame-start pulse from BRIEF stage
//  i_end            in   1    frame-end pulse from BRIEF stage
//  i_flag           in   1    record valid this cycle (no backpressure upstream)
//  i_coor_x         in   10   keypoint x
//  i_coor_y         in   10   keypoint y
//  i_score          in   8    keypoint score
//  i_depth          in   10   keypoint depth
//  i_descriptor     in   256  BRIEF descriptor
//  o_valid          out  1    output record valid
//  i_ready          in   1    matcher accepts record
//  o_coor_x/o_coor_y out 10   record x / y
//  o_score          out  8    record score
//  o_depth          out  10   record depth
//  o_descriptor     out  256  record descriptor
//  o_last           out  1    marks final record of a frame (qualified by o_valid)
//  o_frame_done     out  1    1-cycle pulse: frame handed to read side
//  o_frame_count    out  ADDR_W+1  record count of frame being drained (held until next handoff)
//  o_overflow       out  1    1-cycle pulse at handoff if records were dropped (bank full)
//  o_frame_drop     out  1    1-cycle pulse: completed frame discarded (read side busy)
// BEHAVIOUR
//  - Clock/reset: single clock; i_rst is sampled synchronously on the rising edge of i_clk.
//  - Reset values: all outputs 0. Writer state is W_IDLE; reader state is R_IDLE; write bank is 0; both counts are 0.
//  - Writer FSM W_IDLE/W_FRAME:
//    - W_IDLE -> W_FRAME on i_start; the write count is cleared.
//    - In W_FRAME, i_flag writes a 294b record at wr_cnt and increments wr_cnt.
//    - When wr_cnt == DEPTH, further i_flag records are dropped and the sticky ovf bit is set.
//    - i_flag in W_IDLE is ignored.
//  - Close on i_end in W_FRAME:
//    - An i_flag in the same cycle is written first, then the frame closes.
//    - If the reader is in R_IDLE: bank roles swap and o_frame_done pulses the next cycle.
//      o_frame_count = final count. o_overflow pulses with o_frame_done if ovf was set.
//    - If the reader is busy: o_frame_drop pulses, the bank is not swapped, and its contents are discarded.
//    - The writer returns to W_IDLE.
//  - i_start in W_FRAME without i_end, or with i_end in the same cycle:
//    - The current frame closes exactly as for i_end.
//    - The writer then re-enters W_FRAME with count 0 in the same cycle.
//  - i_end in W_IDLE is ignored.
//  - Reader FSM R_IDLE/R_DRAIN:
//    - On handoff with count>0: R_IDLE -> R_DRAIN. o_valid asserts 1 cycle after o_frame_done, presenting record 0.
//    - A handshake (o_valid&&i_ready) advances rd_ptr. The next record is presented in the following cycle;
//      one record per cycle is sustained when i_ready is held high.
//    - o_valid is deasserted on a handshake only after the last record.
//    - While o_valid && !i_ready, all o_* data fields and o_last are held stable.
//    - o_last = (rd_ptr == count-1). After the last handshake, the reader returns to R_IDLE.
//    - Handoff with count==0: o_frame_done pulses, there are no o_valid beats, and the reader stays in R_IDLE.
//  - Storage: 2 x DEPTH x 294b with a registered read. Write and read use different banks, so there is never a collision.
//  - Reset mid-frame or mid-drain: all state is cleared; partial frames are discarded, and o_valid drops the cycle after i_rst.
// TESTING
//  - Frame with 3 i_flag records then i_end -> o_frame_done, o_frame_count=3.
//    3 beats in order with i_ready=1; o_last on 3rd only.
//  - Same 3-record frame with i_ready toggling 1,0,0,1,... -> data and o_last held during stalls; no record lost or repeated.
//  - DEPTH+5 records in one frame -> o_frame_count=DEPTH and o_overflow=1 at handoff; first DEPTH records drained intact.
//  - Frame B ends while frame A still draining (i_ready=0) -> o_frame_drop pulse.
//    A drains completely; next frame C is handed off normally.
//  - i_start with i_end and i_flag in same cycle (2 prior records) -> old frame count=3 handed off; new frame opens with count 0.
//  - i_rst asserted mid-drain -> o_valid=0 next cycle, counts 0; a following 1-record frame drains correctly.
//    Empty frame (start,end) -> o_frame_done, count 0, no o_valid.

Source files
------------

// File: rtl/brief_desc_collector.sv
// Collects per-frame BRIEF keypoint records into a ping-pong bank pair and drains
// each completed frame to the matcher over a valid/ready port.
module brief_desc_collector #(
  parameter int DEPTH = 128,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_end,
  input  logic              i_flag,
  input  logic [9:0]        i_coor_x,
  input  logic [9:0]        i_coor_y,
  input  logic [7:0]        i_score,
  input  logic [9:0]        i_depth,
  input  logic [255:0]      i_descriptor,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [9:0]        o_coor_x,
  output logic [9:0]        o_coor_y,
  output logic [7:0]        o_score,
  output logic [9:0]        o_depth,
  output logic [255:0]      o_descriptor,
  output logic              o_last,
  output logic              o_frame_done,
  output logic [ADDR_W:0]   o_frame_count,
  output logic              o_overflow,
  output logic              o_frame_drop
);
  localparam int REC_W = 294;
  localparam logic [ADDR_W:0] CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic {W_IDLE = 1'b0, W_FRAME = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} r_state_t;

  w_state_t         w_state_r;
  r_state_t         r_state_r;
  logic             wr_bank_r;
  logic [ADDR_W:0]  wr_cnt_r;
  logic             ovf_r;
  logic [ADDR_W:0]  rd_ptr_r;
  logic [REC_W-1:0] mem_r [0:2*DEPTH-1];

  logic             full_s;
  logic             wr_en_s;
  logic             close_s;
  logic             handoff_s;
  logic             ovf_final_s;
  logic [ADDR_W:0]  final_cnt_s;
  logic             hs_s;
  logic             load_s;
  logic [REC_W-1:0] wr_rec_s;
  logic [REC_W-1:0] rd_rec_s;

  // Write-side decode: a same-cycle record lands before the frame closes.
  always_comb begin
    full_s      = 1'b0;
    wr_en_s     = 1'b0;
    close_s     = 1'b0;
    handoff_s   = 1'b0;
    ovf_final_s = 1'b0;
    final_cnt_s = wr_cnt_r;
    wr_rec_s    = {i_coor_x, i_coor_y, i_score, i_depth, i_descriptor};
    rd_rec_s    = mem_r[{~wr_bank_r, rd_ptr_r[ADDR_W-1:0]}];
    hs_s        = o_valid && i_ready;
    load_s      = (r_state_r == R_DRAIN) && (!o_valid || i_ready) && (rd_ptr_r != o_frame_count);
    if (w_state_r == W_FRAME) begin
      full_s      = (wr_cnt_r == CNT_FULL);
      wr_en_s     = i_flag && !full_s;
      close_s     = i_end || i_start;
      handoff_s   = close_s && (r_state_r == R_IDLE);
      ovf_final_s = ovf_r || (i_flag && full_s);
      final_cnt_s = wr_en_s ? (wr_cnt_r + CNT_ONE) : wr_cnt_r;
    end else begin
      full_s      = 1'b0;
    end
  end

  // Record storage write port; never targets the bank being drained.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      mem_r[{wr_bank_r, wr_cnt_r[ADDR_W-1:0]}] <= wr_rec_s;
    end
  end

  // Writer FSM, bank swap and handoff status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state_r     <= W_IDLE;
      wr_bank_r     <= 1'b0;
      wr_cnt_r      <= CNT_ZERO;
      ovf_r         <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_count <= CNT_ZERO;
      o_overflow    <= 1'b0;
      o_frame_drop  <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
      o_frame_drop <= 1'b0;
      if (wr_en_s) begin
        wr_cnt_r <= wr_cnt_r + CNT_ONE;
      end
      if ((w_state_r == W_FRAME) && i_flag && full_s) begin
        ovf_r <= 1'b1;
      end
      if (handoff_s) begin
        wr_bank_r     <= ~wr_bank_r;
        o_frame_done  <= 1'b1;
        o_frame_count <= final_cnt_s;
        o_overflow    <= ovf_final_s;
      end
      if (close_s && (r_state_r != R_IDLE)) begin
        o_frame_drop <= 1'b1;
      end
      case (w_state_r)
        W_IDLE: begin
          if (i_start) begin
            w_state_r <= W_FRAME;
            wr_cnt_r  <= CNT_ZERO;
            ovf_r     <= 1'b0;
          end
        end
        W_FRAME: begin
          if (close_s) begin
            wr_cnt_r <= CNT_ZERO;
            ovf_r    <= 1'b0;
            // A start while open reopens a fresh frame in the same cycle.
            w_state_r <= i_start ? W_FRAME : W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
        end
      endcase
    end
  end

  // Reader FSM: registered read of the idle bank into the output stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_r    <= R_IDLE;
      rd_ptr_r     <= CNT_ZERO;
      o_valid      <= 1'b0;
      o_last       <= 1'b0;
      o_coor_x     <= 10'd0;
      o_coor_y     <= 10'd0;
      o_score      <= 8'd0;
      o_depth      <= 10'd0;
      o_descriptor <= 256'd0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (handoff_s && (final_cnt_s != CNT_ZERO)) begin
            r_state_r <= R_DRAIN;
            rd_ptr_r  <= CNT_ZERO;
          end
        end
        R_DRAIN: begin
          if (hs_s && o_last) begin
            r_state_r <= R_IDLE;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
          end else if (load_s) begin
            {o_coor_x, o_coor_y, o_score, o_depth, o_descriptor} <= rd_rec_s;
            o_valid  <= 1'b1;
            o_last   <= ((rd_ptr_r + CNT_ONE) == o_frame_count);
            rd_ptr_r <= rd_ptr_r + CNT_ONE;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
        end
      endcase
    end
  end
endmodule
